nx_fifo_rd_prefetch: RTL and testbench
======================================

Name: nx_fifo_rd_prefetch

Overview:
- Read-side stage directly downstream of nx_fifo_ctrl plus its storage RAM.
- Drives the controller's ren from its empty flag, captures RAM read data after a fixed read latency, and presents it as a registered valid/ready stream.
- Hides RAM read latency so consumers get full-rate, back-pressurable output with no combinational path from out_ready to RAM.

Parameters:
- DATA_W, 32, payload width of RAM read data and out_data.
- RD_LAT, 1, RAM read latency in clocks from fifo_ren to valid mem_rdata; legal values 1..3.
- CAP, RD_LAT+1 (derived, localparam), prefetch buffer entries; the minimum for full throughput.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous flush, shared with the controller's clear.
- fifo_empty  in  1  controller empty flag.
- fifo_ren  out  1  read enable to controller; RAM address is the controller's rptr.
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after fifo_ren.
- out_valid  out  1  output entry available.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  head entry payload.
- out_count  out  $clog2(CAP+1)  entries currently buffered.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_count=0, inflight pipe all invalid, buffer pointers 0. fifo_ren=0 while rst_n=0.
- pop = out_valid & out_ready.
- fifo_ren = ~fifo_empty & ~clear & (occ + inflight - pop < CAP). Never asserted while fifo_empty=1, so controller underflow is impossible.
- inflight: RD_LAT-deep shift register of valid bits, input fifo_ren. Its output pushes mem_rdata into the buffer that cycle.
- Buffer: CAP-entry circular register file with wr_ptr/rd_ptr wrapping at CAP (non-power-of-two wrap is explicit, not by overflow) and occ counter.
  - push & ~pop: occ+1.
  - pop & ~push: occ-1.
  - push & pop: occ unchanged, both pointers advance.
- out_valid = (occ != 0), registered. out_data = buf[rd_ptr].
- Latency: fifo_empty falls in cycle T gives fifo_ren in T and out_valid in T+RD_LAT+1.
- Throughput: with out_ready held 1 and the source non-empty, one transfer per clock.
- Stall: out_valid=1 & out_ready=0 holds out_data and out_valid stable. fifo_ren stops once occ+inflight=CAP. Buffer never overflows; a push into a full buffer is a protocol error (assertion).
- Simultaneous push and pop with occ=CAP: legal, no overflow.
- clear=1 in cycle T, effective from T+1:
  - occ=0, pointers=0, out_valid=0.
  - All inflight bits cleared; data returning from pre-clear reads is dropped.
  - fifo_ren=0 in T.
  - A pop in T still counts as transferred.
- Reset mid-operation: all state returns to reset values asynchronously. Pending RAM returns are ignored.
- out_count = occ.

Optional Feature:
- Macro NX_FIFO_RD_PREFETCH_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] (cycles with out_valid & ~out_ready) and starve_cnt[31:0] (cycles with ~out_valid & out_ready & ~fifo_empty).
  - Both saturate at all-ones, reset to 0 by rst_n, and are cleared by clear.
- Undefined: ports and counters are absent; no other behaviour change.

Decomposition:
- Shared package nx_fifo_prefetch_pkg:
  - function prefetch_cap(rd_lat) = rd_lat+1.
  - function cnt_w(cap) = $clog2(cap+1).
  - constant NX_PREFETCH_MAX_LAT = 3.
- One sub-module, nx_fifo_prefetch_buf: CAP-entry register FIFO with push/pop/clear, occ and head-data outputs. The top level holds the ren credit logic, the inflight pipe and the perf counters.

Test Plan:
- Reset, then RD_LAT=1, fifo_empty=0 at T, out_ready=1 → fifo_ren at T, out_valid at T+2; 16 words 0x0..0xF emerge in order, one per clock.
- out_ready=0 for 10 cycles with source non-empty, RD_LAT=2 → fifo_ren pulses exactly 3 times, out_count=3, out_data holds its first value; release out_ready → 3 buffered words then streaming continue with no gap or duplicate.
- fifo_empty toggles every cycle, out_ready random 50% → scoreboard shows no loss, duplication or reordering, and fifo_ren is never high with fifo_empty=1.
- clear at a cycle with occ=2 and 1 read inflight (RD_LAT=2) → next cycle out_valid=0, out_count=0; the returning inflight word (0xDEAD) never appears on out_data.
- rst_n asserted mid-stream with occ=2 → out_valid and out_count drop to 0 asynchronously, before the next clk edge; after release, the first fifo_ren appears only when fifo_empty=0.
- With NX_FIFO_RD_PREFETCH_PERF_EN: 5 stall cycles and 3 starve cycles → stall_cnt=5, starve_cnt=3; clear → both 0.

Source files
------------

// File: rtl/nx_fifo_prefetch_pkg.sv
// Shared constants and sizing helpers for the FIFO read-side prefetch stage.
package nx_fifo_prefetch_pkg;

    localparam int NX_PREFETCH_MAX_LAT = 3;

    function automatic int prefetch_cap(input int rd_lat);
        return rd_lat + 1;
    endfunction

    function automatic int cnt_w(input int cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/nx_fifo_rd_prefetch_if.sv
// Controller/RAM-facing and consumer-facing signals of the read prefetch stage.
interface nx_fifo_rd_prefetch_if
    import nx_fifo_prefetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = cnt_w(prefetch_cap(1))
);
    logic              fifo_empty;
    logic              fifo_ren;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;

    // master: the environment (controller, RAM, consumer); slave: the prefetch stage.
    modport master (
        output fifo_empty, mem_rdata, out_ready,
        input  fifo_ren, out_valid, out_data, out_count
    );

    modport slave (
        input  fifo_empty, mem_rdata, out_ready,
        output fifo_ren, out_valid, out_data, out_count
    );
endinterface

// File: rtl/nx_fifo_prefetch_buf.sv
// CAP-entry circular register FIFO holding words returned from the RAM.
module nx_fifo_prefetch_buf
    import nx_fifo_prefetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CAP    = 2,
    parameter int CNT_W  = cnt_w(CAP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  occ,
    output logic [DATA_W-1:0] head_data
);
    localparam int               PTR_W = (CAP > 1) ? $clog2(CAP) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(CAP - 1);

    logic [DATA_W-1:0] mem_q [CAP];
    logic [DATA_W-1:0] mem_d [CAP];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              pop_ok;

    assign pop_ok = pop && (occ_q != '0);

    // CAP need not be a power of two, so pointers wrap explicitly at LAST.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset because head_data is a visible output with a defined reset value.
            for (int i = 0; i < CAP; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[rd_ptr_q];

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop_ok && !clear && (occ_q == CNT_W'(CAP))));

endmodule

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetch stage: issues FIFO reads against buffer credit and streams RAM data out.
// Optional NX_FIFO_RD_PREFETCH_PERF_EN adds stall_cnt/starve_cnt performance counters.
module nx_fifo_rd_prefetch
    import nx_fifo_prefetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    nx_fifo_rd_prefetch_if.slave bus
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          starve_cnt
`endif
);
    localparam int CAP   = prefetch_cap(RD_LAT);
    localparam int CNT_W = cnt_w(CAP);
    localparam int SUM_W = CNT_W + 1;

    if (RD_LAT < 1 || RD_LAT > NX_PREFETCH_MAX_LAT) begin : g_bad_lat
        $error("nx_fifo_rd_prefetch: RD_LAT out of range");
    end

    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]  occ;
    logic [DATA_W-1:0] head_data;
    logic [SUM_W-1:0]  inflight_cnt;
    logic [SUM_W-1:0]  committed;
    logic              pop;
    logic              push;
    logic              ren;

    assign pop  = bus.out_valid && bus.out_ready;
    assign push = inflight_q[RD_LAT-1] && !clear;

    // A read is issued only if the word it returns is guaranteed a buffer slot.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) inflight_cnt = inflight_cnt + SUM_W'(inflight_q[i]);
        committed  = SUM_W'(occ) + inflight_cnt - SUM_W'(pop);
        ren        = rst_n && !bus.fifo_empty && !clear && (committed < SUM_W'(CAP));
        inflight_d = '0;
        if (!clear) begin
            inflight_d[0] = ren;
            for (int i = 1; i < RD_LAT; i++) inflight_d[i] = inflight_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= '0;
        else        inflight_q <= inflight_d;
    end

    nx_fifo_prefetch_buf #(
        .DATA_W (DATA_W),
        .CAP    (CAP),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (bus.mem_rdata),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

    assign bus.fifo_ren  = ren;
    assign bus.out_valid = (occ != '0);
    assign bus.out_data  = head_data;
    assign bus.out_count = occ;

`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if (clear) begin
            stall_cnt_d  = '0;
            starve_cnt_d = '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && !(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (!bus.out_valid && bus.out_ready && !bus.fifo_empty && !(&starve_cnt_q))
                starve_cnt_d = starve_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_prefetch.sv
// Self-checking bench: two instances (RD_LAT=1 and RD_LAT=2) driven against a word-order scoreboard.
module tb_nx_fifo_rd_prefetch;

    logic clk;
    logic rst_n;
    logic clear1;
    logic clear2;

    int n_checks;
    int n_fails;

    nx_fifo_rd_prefetch_if #(.DATA_W(32), .CNT_W(2)) if1 ();
    nx_fifo_rd_prefetch_if #(.DATA_W(32), .CNT_W(2)) if2 ();

`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    logic [31:0] stall1, starve1, stall2, starve2;
`endif

    nx_fifo_rd_prefetch #(.DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear1),
        .bus        (if1.slave)
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
        ,
        .stall_cnt  (stall1),
        .starve_cnt (starve1)
`endif
    );

    nx_fifo_rd_prefetch #(.DATA_W(32), .RD_LAT(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear2),
        .bus        (if2.slave)
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
        ,
        .stall_cnt  (stall2),
        .starve_cnt (starve2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source model: RAM contents indexed by the controller read pointer, returned after RD_LAT clocks.
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [7:0]  rd_idx1, rd_idx2;
    logic [31:0] pipe1;
    logic [31:0] pipe2 [2];
    logic [31:0] exp2 [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx1 <= 8'd0;
            pipe1   <= 32'd0;
        end else begin
            if (if1.fifo_ren) rd_idx1 <= rd_idx1 + 8'd1;
            pipe1 <= if1.fifo_ren ? mem1[rd_idx1] : $urandom;
        end
    end
    assign if1.mem_rdata = pipe1;

    // Every word read from instance 2's source must emerge in order, unless flushed by clear or reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx2  <= 8'd0;
            pipe2[0] <= 32'd0;
            pipe2[1] <= 32'd0;
            exp2.delete();
        end else begin
            if (clear2) exp2.delete();
            if (if2.fifo_ren) begin
                rd_idx2 <= rd_idx2 + 8'd1;
                exp2.push_back(mem2[rd_idx2]);
            end
            pipe2[0] <= if2.fifo_ren ? mem2[rd_idx2] : $urandom;
            pipe2[1] <= pipe2[0];
        end
    end
    assign if2.mem_rdata = pipe2[1];

    task automatic test_reset();
        rst_n = 1'b1;
        clear1 = 1'b0; clear2 = 1'b0;
        if1.fifo_empty = 1'b0; if2.fifo_empty = 1'b0;
        if1.out_ready = 1'b0;  if2.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = $urandom;
            mem2[i] = $urandom;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (if1.fifo_ren !== 1'b0) begin n_fails++; $display("FAIL reset_ren1: got %b want 0", if1.fifo_ren); end
        n_checks++; if (if2.fifo_ren !== 1'b0) begin n_fails++; $display("FAIL reset_ren2: got %b want 0", if2.fifo_ren); end
        n_checks++; if (if1.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid1: got %b want 0", if1.out_valid); end
        n_checks++; if (if2.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid2: got %b want 0", if2.out_valid); end
        n_checks++; if (if1.out_count !== 2'd0) begin n_fails++; $display("FAIL reset_count1: got %0d want 0", if1.out_count); end
        n_checks++; if (if2.out_count !== 2'd0) begin n_fails++; $display("FAIL reset_count2: got %0d want 0", if2.out_count); end
        n_checks++; if (if1.out_data !== 32'd0) begin n_fails++; $display("FAIL reset_data1: got %h want 0", if1.out_data); end
        n_checks++; if (if2.out_data !== 32'd0) begin n_fails++; $display("FAIL reset_data2: got %h want 0", if2.out_data); end
        @(negedge clk);
        if1.fifo_empty = 1'b1; if2.fifo_empty = 1'b1;
        rst_n = 1'b1;
    endtask

    // RD_LAT=1: read in cycle T, valid in T+2, then 16 words back to back.
    task automatic test_latency_stream();
        for (int i = 0; i < 16; i++) mem1[(int'(rd_idx1) + i) % 256] = 32'(i);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if1.fifo_empty = (c >= 16);
            if1.out_ready  = 1'b1;
            #1;
            n_checks++;
            if (if1.fifo_ren !== (c < 16)) begin n_fails++; $display("FAIL stream_ren c=%0d: got %b want %b", c, if1.fifo_ren, (c < 16)); end
            n_checks++;
            if (if1.out_valid !== (c >= 2 && c <= 17)) begin n_fails++; $display("FAIL stream_valid c=%0d: got %b want %b", c, if1.out_valid, (c >= 2 && c <= 17)); end
            if (c >= 2 && c <= 17) begin
                n_checks++;
                if (if1.out_data !== 32'(c - 2)) begin n_fails++; $display("FAIL stream_data c=%0d: got %h want %h", c, if1.out_data, 32'(c - 2)); end
            end
        end
    endtask

    // RD_LAT=2: ten stalled cycles fill exactly CAP=3 entries, then release streams with no gap.
    task automatic test_stall();
        int pulses;
        logic [31:0] exp_w;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b0;
            if2.out_ready  = 1'b0;
            #1;
            if (if2.fifo_ren) pulses++;
            if (c >= 3) begin
                n_checks++;
                if (if2.out_valid !== 1'b1) begin n_fails++; $display("FAIL stall_valid c=%0d: got %b want 1", c, if2.out_valid); end
                n_checks++;
                if (exp2.size() == 0) begin n_fails++; $display("FAIL stall_hold c=%0d: nothing read yet, data=%h", c, if2.out_data); end
                else if (if2.out_data !== exp2[0]) begin n_fails++; $display("FAIL stall_hold c=%0d: got %h want %h", c, if2.out_data, exp2[0]); end
            end
        end
        n_checks++; if (pulses != 3) begin n_fails++; $display("FAIL stall_ren_pulses: got %0d want 3", pulses); end
        n_checks++; if (if2.out_count !== 2'd3) begin n_fails++; $display("FAIL stall_count: got %0d want 3", if2.out_count); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b0;
            if2.out_ready  = 1'b1;
            #1;
            n_checks++;
            if (if2.out_valid !== 1'b1) begin n_fails++; $display("FAIL release_gap c=%0d: valid got %b want 1", c, if2.out_valid); end
            if (if2.out_valid && if2.out_ready) begin
                n_checks++;
                if (exp2.size() == 0) begin n_fails++; $display("FAIL release_data c=%0d: unexpected word %h", c, if2.out_data); end
                else begin
                    exp_w = exp2.pop_front();
                    if (if2.out_data !== exp_w) begin n_fails++; $display("FAIL release_data c=%0d: got %h want %h", c, if2.out_data, exp_w); end
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b1;
            if2.out_ready  = 1'b1;
            #1;
            if (if2.out_valid && if2.out_ready) begin
                n_checks++;
                if (exp2.size() == 0) begin n_fails++; $display("FAIL stall_drain c=%0d: unexpected word %h", c, if2.out_data); end
                else begin
                    exp_w = exp2.pop_front();
                    if (if2.out_data !== exp_w) begin n_fails++; $display("FAIL stall_drain c=%0d: got %h want %h", c, if2.out_data, exp_w); end
                end
            end
        end
        n_checks++; if (exp2.size() != 0) begin n_fails++; $display("FAIL stall_lost: %0d words never emerged, want 0", exp2.size()); end
        n_checks++; if (if2.out_valid !== 1'b0) begin n_fails++; $display("FAIL stall_idle: valid got %b want 0", if2.out_valid); end
    endtask

    // Toggling source, random consumer: no loss, duplication or reordering; never read an empty FIFO.
    task automatic test_random();
        logic [31:0] exp_w;
        for (int i = 0; i < 256; i++) mem2[i] = $urandom;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if2.fifo_empty = (c % 2 == 1);
            if2.out_ready  = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (if2.fifo_ren && if2.fifo_empty) begin n_fails++; $display("FAIL rand_underflow c=%0d: ren got 1 want 0 while empty", c); end
            if (if2.out_valid && if2.out_ready) begin
                n_checks++;
                if (exp2.size() == 0) begin n_fails++; $display("FAIL rand_data c=%0d: unexpected word %h", c, if2.out_data); end
                else begin
                    exp_w = exp2.pop_front();
                    if (if2.out_data !== exp_w) begin n_fails++; $display("FAIL rand_data c=%0d: got %h want %h", c, if2.out_data, exp_w); end
                end
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b1;
            if2.out_ready  = 1'b1;
            #1;
            if (if2.out_valid && if2.out_ready) begin
                n_checks++;
                if (exp2.size() == 0) begin n_fails++; $display("FAIL rand_drain c=%0d: unexpected word %h", c, if2.out_data); end
                else begin
                    exp_w = exp2.pop_front();
                    if (if2.out_data !== exp_w) begin n_fails++; $display("FAIL rand_drain c=%0d: got %h want %h", c, if2.out_data, exp_w); end
                end
            end
        end
        n_checks++; if (exp2.size() != 0) begin n_fails++; $display("FAIL rand_lost: %0d words never emerged, want 0", exp2.size()); end
    endtask

    // Clear with two words buffered and 0xDEAD returning the same cycle: flushed, never presented.
    task automatic test_clear();
        logic [31:0] exp_w;
        int base;
        base = int'(rd_idx2);
        for (int i = 0; i < 2; i++) begin
            mem2[(base + i) % 256] = $urandom;
            if (mem2[(base + i) % 256] == 32'hDEAD) mem2[(base + i) % 256] = 32'h1;
        end
        mem2[(base + 2) % 256] = 32'hDEAD;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b0;
            if2.out_ready  = 1'b0;
        end
        @(negedge clk);
        clear2         = 1'b1;
        if2.fifo_empty = 1'b0;
        if2.out_ready  = 1'b1;
        #1;
        n_checks++; if (if2.fifo_ren !== 1'b0) begin n_fails++; $display("FAIL clear_ren: got %b want 0", if2.fifo_ren); end
        n_checks++; if (if2.out_count !== 2'd2) begin n_fails++; $display("FAIL clear_pre_count: got %0d want 2", if2.out_count); end
        n_checks++;
        if (exp2.size() == 0) begin n_fails++; $display("FAIL clear_pop: nothing read, data=%h", if2.out_data); end
        else begin
            exp_w = exp2.pop_front();
            if (if2.out_valid !== 1'b1 || if2.out_data !== exp_w) begin
                n_fails++; $display("FAIL clear_pop: got valid=%b data=%h want valid=1 data=%h", if2.out_valid, if2.out_data, exp_w);
            end
        end
        @(negedge clk);
        clear2         = 1'b0;
        if2.fifo_empty = 1'b1;
        if2.out_ready  = 1'b1;
        #1;
        n_checks++; if (if2.out_count !== 2'd0) begin n_fails++; $display("FAIL clear_count: got %0d want 0", if2.out_count); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (if2.out_valid !== 1'b0) begin n_fails++; $display("FAIL clear_valid c=%0d: got %b want 0 (data %h)", c, if2.out_valid, if2.out_data); end
            @(negedge clk);
            #1;
        end
    endtask

`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    // Three starve cycles then five stall cycles; clear zeroes both counters.
    task automatic test_perf();
        @(negedge clk);
        clear2 = 1'b1; if2.fifo_empty = 1'b1; if2.out_ready = 1'b0;
        @(negedge clk);
        clear2 = 1'b0;
        #1;
        n_checks++; if (stall2 !== 32'd0 || starve2 !== 32'd0) begin n_fails++; $display("FAIL perf_init: stall=%0d starve=%0d want 0 0", stall2, starve2); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b0; if2.out_ready = 1'b1;
            #1;
            n_checks++; if (if2.out_valid !== 1'b0) begin n_fails++; $display("FAIL perf_starve_valid c=%0d: got %b want 0", c, if2.out_valid); end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b1; if2.out_ready = 1'b0;
            #1;
            n_checks++; if (if2.out_valid !== 1'b1) begin n_fails++; $display("FAIL perf_stall_valid c=%0d: got %b want 1", c, if2.out_valid); end
        end
        @(negedge clk);
        clear2 = 1'b1; if2.fifo_empty = 1'b1; if2.out_ready = 1'b0;
        #1;
        n_checks++; if (stall2 !== 32'd5) begin n_fails++; $display("FAIL perf_stall: got %0d want 5", stall2); end
        n_checks++; if (starve2 !== 32'd3) begin n_fails++; $display("FAIL perf_starve: got %0d want 3", starve2); end
        @(negedge clk);
        clear2 = 1'b0;
        #1;
        n_checks++; if (stall2 !== 32'd0) begin n_fails++; $display("FAIL perf_stall_clear: got %0d want 0", stall2); end
        n_checks++; if (starve2 !== 32'd0) begin n_fails++; $display("FAIL perf_starve_clear: got %0d want 0", starve2); end
    endtask
`endif

    // Asynchronous reset mid-stream; afterwards reads resume only once the source is non-empty.
    task automatic test_async_reset();
        logic [31:0] exp_w;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b0;
            if2.out_ready  = 1'b0;
        end
        @(negedge clk);
        #1;
        n_checks++; if (if2.out_count !== 2'd2) begin n_fails++; $display("FAIL areset_pre_count: got %0d want 2", if2.out_count); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (if2.out_valid !== 1'b0) begin n_fails++; $display("FAIL areset_valid: got %b want 0", if2.out_valid); end
        n_checks++; if (if2.out_count !== 2'd0) begin n_fails++; $display("FAIL areset_count: got %0d want 0", if2.out_count); end
        n_checks++; if (if2.fifo_ren !== 1'b0) begin n_fails++; $display("FAIL areset_ren: got %b want 0", if2.fifo_ren); end
        @(negedge clk);
        rst_n = 1'b1; if2.fifo_empty = 1'b1; if2.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b1;
            #1;
            n_checks++; if (if2.fifo_ren !== 1'b0) begin n_fails++; $display("FAIL areset_idle_ren c=%0d: got %b want 0", c, if2.fifo_ren); end
        end
        @(negedge clk);
        if2.fifo_empty = 1'b0;
        #1;
        n_checks++; if (if2.fifo_ren !== 1'b1) begin n_fails++; $display("FAIL areset_first_ren: got %b want 1", if2.fifo_ren); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if2.fifo_empty = 1'b1;
            #1;
            if (if2.out_valid && if2.out_ready) begin
                n_checks++;
                if (exp2.size() == 0) begin n_fails++; $display("FAIL areset_data c=%0d: unexpected word %h", c, if2.out_data); end
                else begin
                    exp_w = exp2.pop_front();
                    if (if2.out_data !== exp_w) begin n_fails++; $display("FAIL areset_data c=%0d: got %h want %h", c, if2.out_data, exp_w); end
                end
            end
        end
        n_checks++; if (exp2.size() != 0) begin n_fails++; $display("FAIL areset_lost: %0d words never emerged, want 0", exp2.size()); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_latency_stream();
        test_stall();
        test_random();
        test_clear();
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
        test_perf();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
